bullet_fire_ctrl: RTL and testbench
===================================

Name: bullet_fire_ctrl

Overview:
Produces the per-slot bullet display flags that the bullet position module consumes. Detects fire-button presses and allocates the lowest-index free slot. Enforces a cooldown between shots. Retires a slot when its bullet leaves the top of the screen or hits an enemy. Runs on the frame clock beside the bullet module and also drives sound and score logic.

Parameters:
BulletCount, 2, number of bullet slots; must match the bullet position module.
CooldownFrames, 8, frames after a launch during which further fire presses are dropped (must be >= 1).
TopLimit, 10'd8, a bullet whose y is <= TopLimit is off-screen.
ScreenHeight, 10'd480, a bullet whose y is >= ScreenHeight has wrapped below 0 and is off-screen.

Ports:
frame_clk_i  in  1  frame clock; all state updates on its rising edge.
reset_n_i  in  1  asynchronous active-low reset.
game_active_i  in  1  low means game paused or over; clears all bullets.
fire_i  in  1  fire key level, already synchronous to frame_clk_i.
bullet_y_i  in  [9:0] x BulletCount (unpacked)  current y of each slot, from the bullet position module.
bullet_hit_i  in  1 x BulletCount  collision flag per slot, from the collision logic.
bullet_display_o  out  1 x BulletCount  slot is in flight.
fire_pulse_o  out  1  one-frame pulse on each successful launch.
cooldown_busy_o  out  1  high while in COOLDOWN.
shots_fired_o  out  16  successful launches, saturating at 16'hFFFF.
hits_o  out  16  retirements caused by a hit, saturating.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - all bullet_display_o = 0; fire_pulse_o = 0; cooldown_busy_o = 0.
  - both counters = 0; fire_q = 0; FSM = ARMED; cooldown counter = 0.
- Press detect: press = fire_i & ~fire_q, where fire_q is fire_i registered on the previous edge. A held key fires once only.
- FSM states: ARMED, COOLDOWN.
  - ARMED: on press with at least one slot free, launch and go to COOLDOWN with cnt = CooldownFrames-1. Press with no free slot is dropped: no pulse, no count, stay ARMED.
  - COOLDOWN: cnt decrements each frame. When cnt == 0, go to ARMED on the next edge. Presses during COOLDOWN are dropped, not queued.
- Launch: the lowest-index slot with display == 0 (as registered before this edge) is set to 1. fire_pulse_o = 1 for exactly that frame. shots_fired_o increments. Latency: display goes high on the same edge that samples the press.
- Retire: a slot with display == 1 clears on an edge where bullet_hit_i[i] is 1, or bullet_y_i[i] <= TopLimit, or bullet_y_i[i] >= ScreenHeight. Compare unsigned on 10 bits.
- hits_o increments by the number of slots retired by a hit on that edge. If two slots are hit together, add 2, saturating. Hit and off-screen on the same edge count as one hit.
- bullet_hit_i on a slot with display == 0 is ignored.
- A slot retired on edge k is not free until edge k+1. A launch never targets a slot retiring on the same edge.
- game_active_i low on an edge:
  - all displays clear; FSM goes to ARMED; cnt = 0; fire_pulse_o = 0.
  - counters hold; fire_q keeps tracking fire_i.
  - No launches occur while inactive.
- Reset mid-flight forces the reset values immediately. The bullet module then reattaches bullets to the ship.

Decomposition:
- Shared package galaga_pkg holds:
  - the fire_state_e enum {ARMED, COOLDOWN};
  - SCREEN_HEIGHT and BULLET_TOP_LIMIT constants;
  - SCORE_CNT_W = 16 and BULLET_COUNT_DEFAULT = 2.
- One natural sub-module: bullet_slot_arbiter. It is a combinational lowest-index-free priority encoder giving a found flag and an index. It is reused later for enemy missile slots.

Test Plan:
- Reset and single shot: release reset; fire_i 0->1 at frame 3 -> display[0] = 1 and fire_pulse_o = 1 at frame 3 only; shots_fired_o = 1; cooldown_busy_o high for frames 3..10.
- Held key and cooldown: hold fire_i high 20 frames -> exactly one launch. Press again at frame 5 after the first launch -> dropped. Press at frame 9 -> display[1] = 1.
- Slots full: both displays set, third press after cooldown -> no pulse, count unchanged. Drive bullet_y_i[0] = 8 -> display[0] clears; next press -> slot 0 reused.
- Wrap retire: bullet_y_i[1] = 10'd1020 with display[1] = 1 -> clears next edge; hits_o unchanged.
- Simultaneous hits: both slots active, bullet_hit_i = {1,1}, with bullet_y_i[0] = 3 -> both clear; hits_o += 2. A hit on an inactive slot -> no change.
- Pause and async reset: game_active_i low with bullets in flight and cooldown active -> all clear, ARMED, counters held. Assert reset_n_i mid-frame -> outputs zero without waiting for a clock edge.

Source files
------------

// File: rtl/galaga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : galaga_pkg
//  Description : Shared types and constants for the Galaga-style game blocks.
//                Holds the fire FSM state encoding, screen geometry limits
//                used for bullet retirement, and score counter sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package galaga_pkg;

    // Fire controller states: ARMED accepts a press, COOLDOWN drops presses.
    typedef enum logic [0:0] {
        ARMED    = 1'b0,
        COOLDOWN = 1'b1
    } fire_state_e;

    // Bullets at or above this y (numerically <=) have left the top.
    localparam logic [9:0] BULLET_TOP_LIMIT = 10'd8;

    // y values at or beyond this have wrapped below zero.
    localparam logic [9:0] SCREEN_HEIGHT = 10'd480;

    localparam int unsigned SCORE_CNT_W          = 16;
    localparam int unsigned BULLET_COUNT_DEFAULT = 2;

endpackage : galaga_pkg
`default_nettype wire

// File: rtl/bullet_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_slot_arbiter
//  Description : Combinational lowest-index-first priority encoder over a
//                vector of free-slot flags. Shared by player bullets and
//                enemy missile slot allocation.
//  Ports       : i_free   - one bit per slot, 1 = slot available
//                o_found  - at least one slot is available
//                o_index  - index of the lowest available slot (0 if none)
//  Revision    : 1.0 - initial release
// ============================================================================
module bullet_slot_arbiter
    import galaga_pkg::*;
#(
    parameter int unsigned SLOT_COUNT = BULLET_COUNT_DEFAULT,
    parameter int unsigned IDX_W      = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1
) (
    input  logic [SLOT_COUNT-1:0] i_free,
    output logic                  o_found,
    output logic [IDX_W-1:0]      o_index
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int i = int'(SLOT_COUNT) - 1; i >= 0; i--) begin
            if (i_free[i]) begin
                o_found = 1'b1;
                o_index = IDX_W'(i);
            end
        end
    end

endmodule : bullet_slot_arbiter
`default_nettype wire

// File: rtl/bullet_fire_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_fire_ctrl
//  Description : Player fire controller. Detects fire-key presses, launches
//                into the lowest free bullet slot, enforces a cooldown after
//                each launch, retires slots that leave the screen or hit an
//                enemy, and keeps saturating shot / hit counters.
//  Ports       : frame_clk_i      - frame clock, rising edge
//                reset_n_i        - asynchronous active-low reset
//                game_active_i    - low clears bullets and re-arms
//                fire_i           - fire key level (frame-synchronous)
//                bullet_y_i       - per-slot y from the bullet position block
//                bullet_hit_i     - per-slot collision flag
//                bullet_display_o - per-slot in-flight flag
//                fire_pulse_o     - one-frame pulse per launch
//                cooldown_busy_o  - high while presses are being dropped
//                shots_fired_o    - saturating launch count
//                hits_o           - saturating hit-retirement count
//  Revision    : 1.0 - initial release
// ============================================================================
module bullet_fire_ctrl
    import galaga_pkg::*;
#(
    parameter int unsigned BULLET_COUNT    = BULLET_COUNT_DEFAULT,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter logic [9:0]  TOP_LIMIT       = BULLET_TOP_LIMIT,
    parameter logic [9:0]  SCREEN_H        = SCREEN_HEIGHT
) (
    input  logic                    frame_clk_i,
    input  logic                    reset_n_i,
    input  logic                    game_active_i,
    input  logic                    fire_i,
    input  logic [9:0]              bullet_y_i [BULLET_COUNT],
    input  logic [BULLET_COUNT-1:0] bullet_hit_i,
    output logic [BULLET_COUNT-1:0] bullet_display_o,
    output logic                    fire_pulse_o,
    output logic                    cooldown_busy_o,
    output logic [SCORE_CNT_W-1:0]  shots_fired_o,
    output logic [SCORE_CNT_W-1:0]  hits_o
);

    localparam int unsigned c_IDX_W = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;
    localparam int unsigned c_CD_W  = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam int unsigned c_HIT_W = $clog2(BULLET_COUNT + 1);
    localparam int unsigned c_SUM_W = SCORE_CNT_W + 1;
    localparam logic [c_CD_W-1:0] c_CD_LOAD = c_CD_W'(COOLDOWN_FRAMES - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    fire_state_e              r_state;
    logic [c_CD_W-1:0]        r_cd_cnt;
    logic                     r_fire_q;
    logic [BULLET_COUNT-1:0]  r_display;
    logic                     r_fire_pulse;
    logic                     r_cooldown_busy;
    logic [SCORE_CNT_W-1:0]   r_shots;
    logic [SCORE_CNT_W-1:0]   r_hits;

    // ------------------------------------------------------------------
    // Combinational next-state helpers
    // ------------------------------------------------------------------
    logic                     w_press;
    logic                     w_slot_found;
    logic [c_IDX_W-1:0]       w_slot_idx;
    logic                     w_launch;
    logic [BULLET_COUNT-1:0]  w_launch_mask;
    logic [BULLET_COUNT-1:0]  w_retire;
    logic [BULLET_COUNT-1:0]  w_hit_retire;
    logic [c_HIT_W-1:0]       w_hit_count;
    logic [c_SUM_W-1:0]       w_hits_sum;
    logic [SCORE_CNT_W-1:0]   w_hits_next;
    logic [SCORE_CNT_W-1:0]   w_shots_next;

    assign w_press = fire_i & ~r_fire_q;

    // Free slots come from the pre-edge display, so a slot retiring on
    // this edge still looks busy and cannot be relaunched until the next.
    bullet_slot_arbiter #(
        .SLOT_COUNT (BULLET_COUNT),
        .IDX_W      (c_IDX_W)
    ) u_slot_arbiter (
        .i_free  (~r_display),
        .o_found (w_slot_found),
        .o_index (w_slot_idx)
    );

    assign w_launch = game_active_i & (r_state == ARMED) & w_press & w_slot_found;

    always_comb begin
        w_launch_mask = '0;
        if (w_launch) begin
            w_launch_mask[w_slot_idx] = 1'b1;
        end
    end

    // A hit and an off-screen position on the same edge is one retirement
    // and counts once as a hit.
    always_comb begin
        w_retire     = '0;
        w_hit_retire = '0;
        w_hit_count  = '0;
        for (int i = 0; i < int'(BULLET_COUNT); i++) begin
            w_hit_retire[i] = r_display[i] & bullet_hit_i[i];
            w_retire[i]     = r_display[i] & (bullet_hit_i[i]
                                              | (bullet_y_i[i] <= TOP_LIMIT)
                                              | (bullet_y_i[i] >= SCREEN_H));
            w_hit_count     = w_hit_count + c_HIT_W'(w_hit_retire[i]);
        end
    end

    assign w_hits_sum   = {1'b0, r_hits} + c_SUM_W'(w_hit_count);
    assign w_hits_next  = w_hits_sum[SCORE_CNT_W] ? '1 : w_hits_sum[SCORE_CNT_W-1:0];
    assign w_shots_next = (r_shots == '1) ? r_shots : r_shots + SCORE_CNT_W'(1);

    // ------------------------------------------------------------------
    // FSM, slot flags and counters
    // ------------------------------------------------------------------
    always_ff @(posedge frame_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state         <= ARMED;
            r_cd_cnt        <= '0;
            r_fire_q        <= 1'b0;
            r_display       <= '0;
            r_fire_pulse    <= 1'b0;
            r_cooldown_busy <= 1'b0;
            r_shots         <= '0;
            r_hits          <= '0;
        end else begin
            // Edge detector keeps tracking while paused so a key held
            // through a pause does not fire on resume.
            r_fire_q <= fire_i;

            if (!game_active_i) begin
                r_display       <= '0;
                r_state         <= ARMED;
                r_cd_cnt        <= '0;
                r_fire_pulse    <= 1'b0;
                r_cooldown_busy <= 1'b0;
            end else begin
                r_display    <= (r_display & ~w_retire) | w_launch_mask;
                r_fire_pulse <= w_launch;
                r_hits       <= w_hits_next;
                if (w_launch) begin
                    r_shots <= w_shots_next;
                end

                case (r_state)
                    ARMED: begin
                        if (w_launch) begin
                            r_state         <= COOLDOWN;
                            r_cd_cnt        <= c_CD_LOAD;
                            r_cooldown_busy <= 1'b1;
                        end
                    end
                    COOLDOWN: begin
                        if (r_cd_cnt == '0) begin
                            r_state         <= ARMED;
                            r_cooldown_busy <= 1'b0;
                        end else begin
                            r_cd_cnt <= r_cd_cnt - c_CD_W'(1);
                        end
                    end
                    default: begin
                        r_state         <= ARMED;
                        r_cd_cnt        <= '0;
                        r_cooldown_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bullet_display_o = r_display;
    assign fire_pulse_o     = r_fire_pulse;
    assign cooldown_busy_o  = r_cooldown_busy;
    assign shots_fired_o    = r_shots;
    assign hits_o           = r_hits;

endmodule : bullet_fire_ctrl
`default_nettype wire

// File: tb/tb_bullet_fire_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bullet_fire_ctrl
//  Description : Self-checking bench for bullet_fire_ctrl. A behavioural
//                reference model computes the expected outputs for every
//                frame; they are queued when stimulus is applied and popped
//                and compared one time unit after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bullet_fire_ctrl;

    localparam int c_N  = 2;
    localparam int c_CD = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        active;
    logic        fire;
    logic [9:0]  bullet_y [c_N];
    logic [1:0]  hit;
    logic [1:0]  display;
    logic        pulse;
    logic        busy;
    logic [15:0] shots;
    logic [15:0] hits;

    always #5 clk = ~clk;

    bullet_fire_ctrl #(
        .BULLET_COUNT    (c_N),
        .COOLDOWN_FRAMES (c_CD),
        .TOP_LIMIT       (10'd8),
        .SCREEN_H        (10'd480)
    ) dut (
        .frame_clk_i      (clk),
        .reset_n_i        (reset_n),
        .game_active_i    (active),
        .fire_i           (fire),
        .bullet_y_i       (bullet_y),
        .bullet_hit_i     (hit),
        .bullet_display_o (display),
        .fire_pulse_o     (pulse),
        .cooldown_busy_o  (busy),
        .shots_fired_o    (shots),
        .hits_o           (hits)
    );

    typedef struct packed {
        logic [1:0]  disp;
        logic        pulse;
        logic        busy;
        logic [15:0] shots;
        logic [15:0] hits;
    } exp_t;

    exp_t sb_q[$];

    int n_total = 0;
    int n_bad   = 0;
    int frame_no = 0;

    // Reference model state
    logic [1:0] m_disp;
    logic       m_fire_q;
    logic       m_busy;
    logic       m_pulse;
    int         m_cnt;
    int         m_shots;
    int         m_hits;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s frame=%0d got=%0h exp=%0h", tag, frame_no, got, exp);
        end
    endtask

    task automatic model_reset();
        m_disp   = '0;
        m_fire_q = 1'b0;
        m_busy   = 1'b0;
        m_pulse  = 1'b0;
        m_cnt    = 0;
        m_shots  = 0;
        m_hits   = 0;
    endtask

    task automatic push_expected();
        exp_t e;
        e.disp  = m_disp;
        e.pulse = m_pulse;
        e.busy  = m_busy;
        e.shots = 16'(m_shots);
        e.hits  = 16'(m_hits);
        sb_q.push_back(e);
    endtask

    task automatic model_step(input logic f, input logic act, input int y0, input int y1,
                              input logic [1:0] h);
        logic       press;
        logic       launch;
        logic [1:0] nd;
        int         nh;
        int         slot;
        int         ys[2];
        ys[0] = y0;
        ys[1] = y1;
        press    = f && !m_fire_q;
        m_fire_q = f;
        if (!act) begin
            m_disp  = '0;
            m_busy  = 1'b0;
            m_cnt   = 0;
            m_pulse = 1'b0;
        end else begin
            nd = m_disp;
            nh = 0;
            for (int i = 0; i < c_N; i++) begin
                if (m_disp[i]) begin
                    if (h[i]) nh++;
                    if (h[i] || ys[i] <= 8 || ys[i] >= 480) nd[i] = 1'b0;
                end
            end
            launch = 1'b0;
            if (!m_busy && press) begin
                slot = -1;
                for (int i = c_N - 1; i >= 0; i--) begin
                    if (!m_disp[i]) slot = i;
                end
                if (slot >= 0) begin
                    nd[slot] = 1'b1;
                    launch   = 1'b1;
                end
            end
            if (m_busy) begin
                if (m_cnt == 0) m_busy = 1'b0;
                else            m_cnt--;
            end else if (launch) begin
                m_busy = 1'b1;
                m_cnt  = c_CD - 1;
            end
            m_pulse = launch;
            if (launch && m_shots != 65535) m_shots++;
            m_hits = (m_hits + nh > 65535) ? 65535 : m_hits + nh;
            m_disp = nd;
        end
        push_expected();
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL scoreboard_underflow frame=%0d got=0 exp=1", frame_no);
        end else begin
            e = sb_q.pop_front();
            chk("display",       32'(display), 32'(e.disp));
            chk("fire_pulse",    32'(pulse),   32'(e.pulse));
            chk("cooldown_busy", 32'(busy),    32'(e.busy));
            chk("shots_fired",   32'(shots),   32'(e.shots));
            chk("hits",          32'(hits),    32'(e.hits));
        end
    endtask

    // Called in the low clock phase; returns in the next low phase.
    task automatic frame(input logic f, input logic act, input int y0, input int y1,
                         input logic [1:0] h);
        fire        = f;
        active      = act;
        bullet_y[0] = 10'(y0);
        bullet_y[1] = 10'(y1);
        hit         = h;
        model_step(f, act, y0, y1, h);
        @(posedge clk);
        #1;
        compare_out();
        frame_no++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) frame(1'b0, 1'b1, 200, 200, 2'b00);
    endtask

    task automatic press_once();
        frame(1'b1, 1'b1, 200, 200, 2'b00);
    endtask

    function automatic int rand_y();
        case ($urandom_range(0, 11))
            0:       return 8;
            1:       return 9;
            2:       return 479;
            3:       return 480;
            4:       return 1020;
            default: return int'($urandom_range(10, 478));
        endcase
    endfunction

    initial begin
        reset_n     = 1'b0;
        active      = 1'b1;
        fire        = 1'b0;
        bullet_y[0] = 10'd200;
        bullet_y[1] = 10'd200;
        hit         = 2'b00;
        model_reset();

        // Reset state while reset is held
        repeat (3) @(negedge clk);
        #2;
        push_expected();
        compare_out();
        reset_n = 1'b1;

        // Single shot at frame 3, key held for 20 frames -> one launch
        idle(3);
        repeat (20) frame(1'b1, 1'b1, 200, 200, 2'b00);
        idle(2);

        // Second launch into slot 1; press 5 frames later is dropped by
        // cooldown; press 9 frames later is dropped because slots are full
        press_once();
        idle(4);
        press_once();
        idle(3);
        press_once();
        idle(1);

        // Slot 0 leaves the top, then is reused by the next press
        frame(1'b0, 1'b1, 8, 200, 2'b00);
        press_once();
        idle(2);

        // Slot 1 wraps below zero: retired, hit count unchanged
        frame(1'b0, 1'b1, 200, 1020, 2'b00);
        idle(8);
        press_once();
        idle(1);

        // Both slots hit together, slot 0 also off-screen: +2 hits
        frame(1'b0, 1'b1, 3, 200, 2'b11);
        // Hits on idle slots are ignored
        frame(1'b0, 1'b1, 200, 200, 2'b11);
        idle(8);

        // Pause with a bullet in flight and cooldown running
        press_once();
        idle(1);
        press_once();
        frame(1'b0, 1'b0, 200, 200, 2'b00);
        frame(1'b1, 1'b0, 200, 200, 2'b00);
        frame(1'b0, 1'b1, 200, 200, 2'b00);
        press_once();
        idle(1);

        // Asynchronous reset in the middle of a frame
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        push_expected();
        compare_out();
        #1;
        reset_n = 1'b1;
        idle(2);

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            frame(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) != 0),
                  rand_y(), rand_y(),
                  {1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0)});
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_bullet_fire_ctrl
`default_nettype wire
